// File: rtl/recon_pixel_stream_if.sv
// Symbol-in / pixel-out bundle for recon_pixel_stream.
// master = symbol source and pixel sink; slave = the reconstructor.
interface recon_pixel_stream_if;
    logic        i_vl;
    logic        i_rdy;
    logic        i_run;
    logic [13:0] i_len;
    logic [8:0]  i_err;
    logic        i_s;
    logic        o_vl;
    logic [7:0]  o_x;
    logic        o_eol;
    logic        o_eof;
    logic        o_err;

    modport master (
        output i_vl, i_run, i_len, i_err, i_s,
        input  i_rdy, o_vl, o_x, o_eol, o_eof, o_err
    );

    modport slave (
        input  i_vl, i_run, i_len, i_err, i_s,
        output i_rdy, o_vl, o_x, o_eol, o_eof, o_err
    );
endinterface

// File: rtl/recon_pixel_stream.sv
// Predictive pixel reconstruction from decoded regular/run symbols, one pixel per cycle.
// Define RECON_ERRCHK_EN to build the sticky run-overrun flag on o_err.
module recon_pixel_stream #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic clk,
    input  logic rst,
    recon_pixel_stream_if.slave ps
);
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [13:0]   run_cnt, run_cnt_nxt;
    logic [7:0]    run_val, run_val_nxt;
    logic [7:0]    a_reg;      // last emitted pixel
    logic [7:0]    b_prev;     // b of the previous pixel, i.e. c of the current one
    logic [7:0]    c0_reg;     // b used at column 0 of the previous row
    logic [7:0]    line_buf [IMG_W];

    logic       rdy, accept, emit;
    logic       col_last, row_last;
    logic [7:0] nb_a, nb_b, nb_c, mx, mn, pred, reg_pix, pix;
    logic [9:0] err_ext, e, sum;

    assign rdy      = (state == IDLE) && !rst;
    assign accept   = ps.i_vl && rdy;
    assign col_last = (col == COL_LAST);
    assign row_last = (row == ROW_LAST);
    assign ps.i_rdy = rdy;

    // Neighbourhood and median-edge prediction for the pixel at (row, col).
    always_comb begin
        nb_b = (row == '0) ? 8'd0 : line_buf[col];
        nb_a = (col == '0) ? nb_b : a_reg;
        if (row == '0)
            nb_c = 8'd0;
        else
            nb_c = (col == '0) ? c0_reg : b_prev;
        mx = (nb_a > nb_b) ? nb_a : nb_b;
        mn = (nb_a > nb_b) ? nb_b : nb_a;
        if (nb_c >= mx)
            pred = mn;
        else if (nb_c <= mn)
            pred = mx;
        else
            pred = nb_a + nb_b - nb_c;
        // Residual is widened so that -(-256) does not alias before the final wrap.
        err_ext = {ps.i_err[8], ps.i_err};
        e       = ps.i_s ? -err_ext : err_ext;
        sum     = {2'b00, pred} + e;
        reg_pix = 8'(sum);
    end

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt   = state;
        run_cnt_nxt = run_cnt;
        run_val_nxt = run_val;
        emit        = 1'b0;
        pix         = run_val;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!ps.i_run) begin
                        emit = 1'b1;
                        pix  = reg_pix;
                    end else if (ps.i_len != 14'd0) begin
                        emit        = 1'b1;
                        pix         = nb_a;
                        run_val_nxt = nb_a;
                        // A run never continues past the row end.
                        if (ps.i_len > 14'd1 && !col_last) begin
                            state_nxt   = RUN;
                            run_cnt_nxt = ps.i_len - 14'd1;
                        end
                    end
                end
            end
            RUN: begin
                emit        = 1'b1;
                run_cnt_nxt = run_cnt - 14'd1;
                if (run_cnt == 14'd1 || col_last) begin
                    state_nxt   = IDLE;
                    run_cnt_nxt = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            col      <= '0;
            row      <= '0;
            run_cnt  <= '0;
            run_val  <= '0;
            a_reg    <= '0;
            b_prev   <= '0;
            c0_reg   <= '0;
            ps.o_vl  <= 1'b0;
            ps.o_x   <= '0;
            ps.o_eol <= 1'b0;
            ps.o_eof <= 1'b0;
        end else begin
            state   <= state_nxt;
            run_cnt <= run_cnt_nxt;
            run_val <= run_val_nxt;
            ps.o_vl <= emit;
            if (emit) begin
                ps.o_x   <= pix;
                ps.o_eol <= col_last;
                ps.o_eof <= col_last && row_last;
                a_reg    <= pix;
                b_prev   <= nb_b;
                if (col == '0)
                    c0_reg <= nb_b;
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
        end
    end

    // NOTE: the line buffer is a RAM and is deliberately not reset; row 0 never reads it.
    always_ff @(posedge clk) begin
        if (emit && !rst)
            line_buf[col] <= pix;
    end

`ifdef RECON_ERRCHK_EN
    logic trunc;
    assign trunc = emit && col_last &&
                   ((state == RUN) ? (run_cnt > 14'd1) : (ps.i_run && ps.i_len > 14'd1));

    always_ff @(posedge clk) begin
        if (rst)
            ps.o_err <= 1'b0;
        else if (trunc)
            ps.o_err <= 1'b1;
    end
`else
    assign ps.o_err = 1'b0;
`endif

endmodule

// File: tb/tb_recon_pixel_stream.sv
// Self-checking bench for recon_pixel_stream on a 4x2 image: vector table plus
// hand sequences, with a scoreboard queue checked against every output cycle.
module tb_recon_pixel_stream;
    localparam int W = 4;
    localparam int H = 2;
`ifdef RECON_ERRCHK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    typedef struct {
        logic        run;
        logic [13:0] len;
        logic [8:0]  err;
        logic        s;
        logic [7:0]  exp_x;
        int          exp_n;
        logic        exp_eol;
        logic        exp_eof;
    } vec_t;

    typedef struct {
        logic [7:0] x;
        logic       eol;
        logic       eof;
    } pix_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    recon_pixel_stream_if ps();

    recon_pixel_stream #(.IMG_W(W), .IMG_H(H)) dut (
        .clk (clk),
        .rst (rst),
        .ps  (ps.slave)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_pass   = 0;
    bit   mon_on   = 1'b0;
    pix_t sb[$];
    pix_t mon_e;
    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    endtask

    task automatic push_pixels(input logic [7:0] x, input int n, input logic eol, input logic eof);
        pix_t p;
        for (int k = 0; k < n; k++) begin
            p.x   = x;
            p.eol = (k == n - 1) ? eol : 1'b0;
            p.eof = (k == n - 1) ? eof : 1'b0;
            sb.push_back(p);
        end
    endtask

    // Present one symbol, wait for acceptance, queue its expected pixels.
    task automatic send(input logic run, input logic [13:0] len, input logic [8:0] err,
                        input logic s, input logic [7:0] x, input int n,
                        input logic eol, input logic eof);
        int guard = 0;
        ps.i_vl  = 1'b1;
        ps.i_run = run;
        ps.i_len = len;
        ps.i_err = err;
        ps.i_s   = s;
        while (ps.i_rdy !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50)
            check("accept_timeout", ps.i_rdy, 1'b1);
        @(posedge clk);
        push_pixels(x, n, eol, eof);
        @(negedge clk);
        ps.i_vl = 1'b0;
    endtask

    // Every cycle: a pending expected pixel must appear now, otherwise o_vl must be low.
    always @(negedge clk) begin
        if (mon_on) begin
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("pix_valid", ps.o_vl, 1'b1);
                check("pix_value", {ps.o_eol, ps.o_eof, ps.o_x}, {mon_e.eol, mon_e.eof, mon_e.x});
            end else begin
                check("idle_valid", ps.o_vl, 1'b0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //            run   len      err     s     x      n  eol   eof
        vecs[0]  = '{1'b0, 14'd0, 9'd10,  1'b0, 8'd10,  1, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 14'd0, 9'd20,  1'b0, 8'd30,  1, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 14'd0, 9'd30,  1'b0, 8'd60,  1, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 14'd0, 9'd40,  1'b0, 8'd100, 1, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 14'd3, 9'd0,   1'b0, 8'd10,  1, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 14'd3, 9'd0,   1'b0, 8'd30,  1, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 14'd9, 9'h1ab, 1'b0, 8'd30,  2, 1'b1, 1'b1};
        vecs[7]  = '{1'b0, 14'd0, 9'd2,   1'b0, 8'd2,   1, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 14'd0, 9'd5,   1'b1, 8'd253, 1, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 14'd0, 9'h100, 1'b1, 8'd253, 1, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 14'd0, 9'd0,   1'b0, 8'd0,   0, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 14'd1, 9'd0,   1'b0, 8'd253, 1, 1'b1, 1'b0};

        ps.i_vl  = 1'b0;
        ps.i_run = 1'b0;
        ps.i_len = '0;
        ps.i_err = '0;
        ps.i_s   = 1'b0;
        rst      = 1'b1;
        repeat (3) @(negedge clk);
        check("rdy_in_reset", ps.i_rdy, 1'b0);
        check("reset_o_vl",   ps.o_vl,  1'b0);
        check("reset_o_x",    ps.o_x,   8'd0);
        check("reset_o_eol",  ps.o_eol, 1'b0);
        check("reset_o_eof",  ps.o_eof, 1'b0);
        check("reset_o_err",  ps.o_err, 1'b0);
        rst = 1'b0;
        #1;
        check("rdy_after_reset", ps.i_rdy, 1'b1);
        mon_on = 1'b1;

        // Frame 1 row 0, row 1 with a truncated run; frame 2 row 0 arithmetic corners.
        for (int i = 0; i < 12; i++)
            send(vecs[i].run, vecs[i].len, vecs[i].err, vecs[i].s,
                 vecs[i].exp_x, vecs[i].exp_n, vecs[i].exp_eol, vecs[i].exp_eof);
        check("overrun_flag", ps.o_err, EXP_ERR);

        // Frame 2 row 1: run of 3 at column 0 takes b=2; ready drops for two cycles.
        send(1'b1, 14'd3, 9'd0, 1'b0, 8'd2, 3, 1'b0, 1'b0);
        check("run_rdy_t1", ps.i_rdy, 1'b0);
        @(negedge clk);
        check("run_rdy_t2", ps.i_rdy, 1'b0);
        @(negedge clk);
        check("run_rdy_t3", ps.i_rdy, 1'b1);
        // Regular straight after the run: a=2, b=253, c=253 -> px=2, last pixel of frame.
        send(1'b0, 14'd0, 9'd7, 1'b0, 8'd9, 1, 1'b1, 1'b1);
        // New frame restarts at (0,0) with zero neighbours.
        send(1'b0, 14'd0, 9'd1, 1'b0, 8'd1, 1, 1'b0, 1'b0);

        // Run of 5 at (0,1) aborted by reset in its second cycle; a symbol offered during reset is dropped.
        ps.i_vl  = 1'b1;
        ps.i_run = 1'b1;
        ps.i_len = 14'd5;
        ps.i_err = 9'd0;
        ps.i_s   = 1'b0;
        @(posedge clk);
        push_pixels(8'd1, 1, 1'b0, 1'b0);
        @(negedge clk);
        ps.i_run = 1'b0;
        ps.i_err = 9'd50;
        rst      = 1'b1;
        #1;
        check("rdy_in_abort", ps.i_rdy, 1'b0);
        @(negedge clk);
        rst     = 1'b0;
        ps.i_vl = 1'b0;
        check("abort_err_clear", ps.o_err, 1'b0);
        #1;
        check("rdy_after_abort", ps.i_rdy, 1'b1);
        @(negedge clk);
        send(1'b0, 14'd0, 9'd3, 1'b0, 8'd3, 1, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/recon_pixel_stream.md
RECON_PIXEL_STREAM -- requirements
Module: recon_pixel_stream

Interface
REQ-001 Parameter IMG_W, default 640: image width in pixels, legal range 2..8192.
REQ-002 Parameter IMG_H, default 480: image height in rows, legal range 1..8192.
REQ-003 Port clk  input  1  clock, rising-edge.
REQ-004 Port rst  input  1  synchronous active-high reset.
REQ-005 Port i_vl  input  1  a decoded symbol is presented.
REQ-006 Port i_rdy  output  1  the symbol is consumed on a cycle with i_vl & i_rdy.
REQ-007 Port i_run  input  1  1 = run symbol, 0 = regular symbol.
REQ-008 Port i_len  input  14  run length in pixels; ignored when i_run=0.
REQ-009 Port i_err  input  9  two's-complement residual; ignored when i_run=1.
REQ-010 Port i_s  input  1  context sign: residual is negated when 1.
REQ-011 Port o_vl  output  1  reconstructed pixel valid.
REQ-012 Port o_x  output  8  reconstructed pixel.
REQ-013 Port o_eol / o_eof  output  1 each  pixel is the last of its row / frame; qualified by o_vl.
REQ-014 Port o_err  output  1  sticky run-overrun flag (see REQ-035).

Function
REQ-015 Position counters col (0..IMG_W-1) and row (0..IMG_H-1) SHALL advance on every emitted pixel, wrapping col->0 with row+1 and, at the frame's last pixel, row->0.
REQ-016 Neighbours for the pixel at (row,col): b = pixel above, c = pixel above-left, a = pixel left.
REQ-017 Row 0: b = c = 0. Column 0: a = b; c = the b used at column 0 of the previous row (0 on rows 0 and 1).
REQ-018 A line buffer of IMG_W bytes SHALL hold the previous row; each emitted pixel is written at col after its b has been read.
REQ-019 Prediction: px = min(a,b) if c >= max(a,b); max(a,b) if c <= min(a,b); else a+b-c, 8-bit.
REQ-020 Regular symbol: e = i_s ? -i_err : i_err; o_x = (px + e) mod 256; exactly one pixel.
REQ-021 Run symbol: emits i_len pixels, each equal to a of the first run pixel (b when the run starts at column 0); i_len=0 emits nothing.
REQ-022 Latency: a symbol accepted in cycle t produces its first pixel with o_vl=1 in cycle t+1; run pixels follow one per cycle with no gaps.
REQ-023 FSM states IDLE and RUN; IDLE accepts symbols (i_rdy=1); a run with i_len >= 2 enters RUN with remaining count i_len-1.
REQ-024 In RUN: i_rdy=0; one pixel per cycle; count decrements; return to IDLE in the cycle the last run pixel is emitted, so i_rdy=1 in that cycle.
REQ-025 Back-to-back symbols SHALL sustain one pixel per cycle, including regular directly after a run and a run directly after a regular symbol.
REQ-026 A run SHALL NOT cross a row end: when the run reaches col=IMG_W-1 it ends after that pixel and the remainder is discarded.
REQ-027 o_eol=1 exactly when the emitted pixel has col=IMG_W-1; o_eof=1 when additionally row=IMG_H-1.
REQ-028 After o_eof the next pixel is (0,0) of a new frame and the REQ-017 row-0 rules apply again; line buffer contents are not cleared.
REQ-029 o_vl=0 in every cycle without an emitted pixel; o_x/o_eol/o_eof then hold their previous values.
REQ-030 Residual arithmetic SHALL use at least 10 bits before the mod-256 wrap; i_err=-256 with i_s=1 yields px+256 mod 256 = px.

Reset
REQ-031 On rst: FSM=IDLE, col=0, row=0, run count=0, o_vl=0, o_x=0, o_eol=0, o_eof=0, o_err=0.
REQ-032 rst during RUN SHALL abort the run; no further run pixels are emitted.
REQ-033 rst has priority over a simultaneous i_vl; the symbol is not consumed.
REQ-034 i_rdy=0 in the reset cycle; i_rdy=1 in the first cycle after rst deasserts.

Configuration
REQ-035 With RECON_ERRCHK_EN defined, o_err SHALL be set in the cycle after a run is truncated by REQ-026 and SHALL hold until rst.
REQ-036 Without RECON_ERRCHK_EN, o_err SHALL be constant 0 and the overrun-detection logic SHALL be absent; truncation (REQ-026) still applies.

Verification
REQ-037 IMG_W=4, IMG_H=2; after reset, 4 regular symbols with i_err=10,20,30,40 and i_s=0 -> o_x=10,30,60,100 on consecutive cycles; o_eol only on the 4th.
REQ-038 Row 1 regular with i_err=0 at col 0, b=10 -> px=10, o_x=10; at col 1, a=10, b=30, c=10 -> px=30.
REQ-039 A run with i_len=3 at col 0 of row 1 (b=10) -> three pixels of value 10 in cycles t+1..t+3; i_rdy low in t+1 and t+2, high in t+3.
REQ-040 A run with i_len=9 at col 2, IMG_W=4 -> two pixels, second with o_eol=1; o_err=1 with RECON_ERRCHK_EN, 0 without.
REQ-041 rst asserted in the 2nd cycle of an i_len=5 run -> o_vl=0 from the following cycle; the next symbol reconstructs at (0,0) with b=c=0.
REQ-042 Regular symbol with i_err=5, i_s=1, px=2 -> o_x=253; a final frame pixel followed by one more symbol -> o_eof=1, then col=0, row=0.
